// File: rtl/key_led_pkg.sv
//------------------------------------------------------------------------------
// key_led_pkg : shared constants and helpers for the key/LED front end
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package key_led_pkg;

  localparam logic MODE_FOLLOW = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  function automatic int db_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
//------------------------------------------------------------------------------
// key_debounce : one key channel - synchroniser, debounce, press-edge detect
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module key_debounce
  import key_led_pkg::*;
#(
  parameter int DB_CYCLES      = 1_000_000,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic key,
  output logic level,
  output logic press
);

  localparam int              c_cnt_w    = db_width(DB_CYCLES);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DB_CYCLES - 1);
  localparam logic            c_released = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [1:0]         r_sync;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_level;
  logic               r_level_d;
  logic               r_press;
  logic               w_norm;

  // XOR with the released level maps the pin to "1 = pressed" for either polarity
  assign w_norm = r_sync[1] ^ c_released;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {2{c_released}};
    end else begin
      r_sync <= {r_sync[0], key};
    end
  end

  // Acceptance happens on the cycle the count would reach DB_CYCLES, so the
  // counter never exceeds DB_CYCLES-1 and cannot wrap.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_norm == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt   <= '0;
      r_level <= w_norm;
    end else begin
      r_cnt   <= r_cnt + c_cnt_w'(1);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/key_led_ctrl.sv
//------------------------------------------------------------------------------
// key_led_ctrl : multi-channel debounced keys driving follow/toggle LEDs
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int              N_CH           = 2,
  parameter int              DB_CYCLES      = 1_000_000,
  parameter bit              KEY_ACTIVE_LOW = 1'b1,
  parameter logic [N_CH-1:0] TOGGLE_MASK    = '0
) (
  input  logic            sysclk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] key,
  output logic [N_CH-1:0] led,
  output logic [N_CH-1:0] key_level,
  output logic [N_CH-1:0] key_press
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic r_led;

    key_debounce #(
      .DB_CYCLES      (DB_CYCLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_debounce (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .key    (key[i]),
      .level  (key_level[i]),
      .press  (key_press[i])
    );

    if (TOGGLE_MASK[i] == MODE_TOGGLE) begin : g_toggle
      always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
          r_led <= 1'b0;
        end else begin
          r_led <= r_led ^ key_press[i];
        end
      end
    end else begin : g_follow
      always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
          r_led <= 1'b0;
        end else begin
          r_led <= key_level[i];
        end
      end
    end

    assign led[i] = r_led;
  end

endmodule

`default_nettype wire

// File: tb/tb_key_led_ctrl.sv
//------------------------------------------------------------------------------
// tb_key_led_ctrl : directed bench for key_led_ctrl with a sliding-window model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_led_ctrl;

  localparam int         N_CH  = 2;
  localparam int         DB    = 8;
  localparam logic [1:0] TMASK = 2'b10;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic [1:0] key    = 2'b00;
  logic [1:0] led;
  logic [1:0] key_level;
  logic [1:0] key_press;

  int vectors     = 0;
  int miscompares = 0;

  always #5 sysclk = ~sysclk;

  key_led_ctrl #(
    .N_CH           (N_CH),
    .DB_CYCLES      (DB),
    .KEY_ACTIVE_LOW (1'b1),
    .TOGGLE_MASK    (TMASK)
  ) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .key       (key),
    .led       (led),
    .key_level (key_level),
    .key_press (key_press)
  );

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Model: a level is accepted when the last DB synchronised samples (pins
  // delayed two edges) all disagree with the current level.
  logic [1:0] hist[$];
  logic [1:0] m_level   = 2'b00;
  logic [1:0] m_level_d = 2'b00;
  logic [1:0] m_press   = 2'b00;
  logic [1:0] m_led     = 2'b00;

  initial forever begin
    @(posedge sysclk or negedge rst_n);
    if (!rst_n) begin
      hist.delete();
      m_level   = 2'b00;
      m_level_d = 2'b00;
      m_press   = 2'b00;
      m_led     = 2'b00;
    end else begin
      hist.push_back(~key);
      for (int c = 0; c < N_CH; c++) begin
        if (TMASK[c]) m_led[c] = m_led[c] ^ m_press[c];
        else          m_led[c] = m_level[c];
      end
      m_press   = m_level & ~m_level_d;
      m_level_d = m_level;
      if (hist.size() >= DB + 2) begin
        for (int c = 0; c < N_CH; c++) begin
          bit all_diff;
          all_diff = 1'b1;
          for (int k = hist.size() - 2 - DB; k <= hist.size() - 3; k++)
            if (hist[k][c] == m_level[c]) all_diff = 1'b0;
          if (all_diff) m_level[c] = ~m_level[c];
        end
      end
    end
  end

  initial forever begin
    @(negedge sysclk);
    check("model_level", key_level, m_level);
    check("model_press", key_press, m_press);
    check("model_led",   led,       m_led);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  initial begin
    logic [2:0] tog_exp;
    tog_exp = 3'b101;

    // Keys held pressed through reset
    tick(4);
    check("rst_led",   led,       2'b00);
    check("rst_level", key_level, 2'b00);
    check("rst_press", key_press, 2'b00);
    rst_n = 1'b1;
    tick(9);
    check("rst_level_c9",  key_level, 2'b00);
    tick(1);
    check("rst_level_c10", key_level, 2'b11);
    tick(1);
    check("rst_press_c11", key_press, 2'b11);
    check("rst_led_c11",   led,       2'b01);
    tick(1);
    check("rst_press_c12", key_press, 2'b00);
    check("rst_led_c12",   led,       2'b11);
    key = 2'b11;
    tick(11);
    check("release_led", led, 2'b10);
    tick(5);

    // Clean press on ch0
    key = 2'b10;
    tick(9);
    check("ch0_level_early", key_level, 2'b00);
    tick(1);
    check("ch0_level", key_level, 2'b01);
    tick(1);
    check("ch0_press", key_press, 2'b01);
    check("ch0_led",   led,       2'b11);
    key = 2'b11;
    tick(20);
    check("ch0_release_led", led, 2'b10);

    // Bounce on ch0: 7 pressed, 1 released, then press and hold
    key = 2'b10;
    tick(7);
    key = 2'b11;
    tick(1);
    check("bounce_burst", key_level, 2'b00);
    key = 2'b10;
    tick(9);
    check("bounce_early", key_level, 2'b00);
    tick(1);
    check("bounce_level", key_level, 2'b01);
    key = 2'b11;
    tick(20);

    // Brief reset to start toggle channel from 0
    rst_n = 1'b0;
    tick(2);
    check("rst2_led", led, 2'b00);
    rst_n = 1'b1;
    tick(3);

    // Three presses on toggle channel
    for (int p = 0; p < 3; p++) begin
      key = 2'b01;
      tick(12);
      check("toggle_press", {1'b0, led[1]}, {1'b0, tog_exp[p]});
      key = 2'b11;
      tick(12);
      check("toggle_release", {1'b0, led[1]}, {1'b0, tog_exp[p]});
    end

    // Simultaneous press on both channels
    key = 2'b00;
    tick(10);
    check("sim_level", key_level, 2'b11);
    tick(1);
    check("sim_press", key_press, 2'b11);
    check("sim_led",   led,       2'b11);
    tick(1);
    check("sim_led_toggled", led, 2'b01);
    key = 2'b11;
    tick(20);
    key = 2'b01;
    tick(20);
    key = 2'b11;
    tick(20);
    check("pre_midrst_led", led, 2'b10);

    // Reset 5 cycles into a ch1 debounce
    key = 2'b01;
    tick(7);
    #2 rst_n = 1'b0;
    #1 check("midrst_led", led, 2'b00);
    tick(2);
    rst_n = 1'b1;
    tick(9);
    check("midrst_level_early", key_level, 2'b00);
    tick(1);
    check("midrst_level", key_level, 2'b10);
    tick(1);
    check("midrst_press", key_press, 2'b10);
    tick(1);
    check("midrst_led_after", led, 2'b10);
    key = 2'b11;
    tick(15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_led_ctrl.md
# key_led_ctrl

Parametrised multi-channel push-button front end for board LEDs. Each key is synchronised into `sysclk`, debounced, and edge-detected. Each key then drives its LED either directly (follow mode) or as a press-toggled latch (toggle mode). The block sits between the board key pins and the LED pins, and also exports clean level and press-pulse signals for other logic.

## Interface
- `N_CH`, default 2: number of key/LED channels, 1..16.
- `DB_CYCLES`, default 1_000_000: cycles a new key level must persist before it is accepted (20 ms at 50 MHz). Must be ≥ 2.
- `KEY_ACTIVE_LOW`, default 1: 1 means a pin at 0 is "pressed"; 0 means a pin at 1 is "pressed".
- `TOGGLE_MASK`, default all zeros, `N_CH` bits: bit i = 1 puts channel i in toggle mode; 0 puts it in follow mode.
- `sysclk`  input  1  single system clock; all logic is on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `key`  input  N_CH  raw, asynchronous key pins.
- `led`  output  N_CH  LED drive; 1 = lit.
- `key_level`  output  N_CH  debounced key state; 1 = pressed.
- `key_press`  output  N_CH  one-cycle pulse per accepted press (released→pressed).

## Operation
- Per channel, in pipeline order:
  - Two-flop synchroniser on `key`.
  - Polarity normalisation to "1 = pressed".
  - Debounce counter.
  - Stable-state register, which drives `key_level`.
  - Edge detector, which drives `key_press`.
  - LED logic, which drives `led`.
- Debounce rules:
  - If the normalised synchronised value equals the stable value, the counter clears to 0.
  - If it differs, the counter increments each cycle.
  - On the cycle the counter would reach `DB_CYCLES`, the stable value takes the new level and the counter clears.
  - Any return to the stable value before that clears the counter. The count restarts from 0 on the next difference, with no partial credit.
- Counter width is `$clog2(DB_CYCLES+1)`. It saturates by construction and never wraps.
- `key_press[i]` is 1 for exactly one cycle: the cycle after `key_level[i]` goes 0→1. A release (1→0) produces no pulse.
- Follow mode: `led[i]` is a registered copy of `key_level[i]`.
- Toggle mode: `led[i]` inverts on each cycle where `key_press[i]` is 1, and holds otherwise.
- Channels are fully independent. Simultaneous events on several channels are each handled in full, in the same cycle.
- Reset values: all of `led`, `key_level` and `key_press` are 0. Synchroniser flops reset to the released pin level (1 if `KEY_ACTIVE_LOW`, else 0). Counters reset to 0.
- Asserting `rst_n` mid-debounce discards the partial count. Asserting it in toggle mode clears the LED.
- A key held through reset release counts as a new change: it is accepted `DB_CYCLES` cycles after the synchroniser fills, and then produces a press pulse.

## Timing
- Latency from a pin change (meeting setup before edge 0) to the `key_level` change: 2 cycles synchroniser + `DB_CYCLES` cycles debounce.
- `key_press` follows `key_level` by 1 cycle.
- Follow-mode `led` follows `key_level` by 1 cycle.
- Toggle-mode `led` follows `key_press` by 1 cycle.
- Glitch rejection: any pulse shorter than `DB_CYCLES` synchronised cycles is never reflected on any output.
- Maximum press rate: one accepted press per 2·`DB_CYCLES` cycles (one press interval plus one release interval).
- All outputs are registered. There is no combinational path from `key` to any output.

## Structure
- Package `key_led_pkg`:
  - Localparams `MODE_FOLLOW = 1'b0` and `MODE_TOGGLE = 1'b1`.
  - Function `db_width(int cycles)` returning `$clog2(cycles+1)`.
- Sub-module `key_debounce`, one instance per channel via generate loop:
  - Inputs: `sysclk`, `rst_n`, raw key.
  - Parameters: `DB_CYCLES`, `KEY_ACTIVE_LOW`.
  - Outputs: `level`, `press`.
- Top `key_led_ctrl` holds the per-channel LED logic, selected by `TOGGLE_MASK[i]`.

## Test plan
Bench settings: `DB_CYCLES=8`, `N_CH=2`, `KEY_ACTIVE_LOW=1`, `TOGGLE_MASK=2'b10`.
- Reset: hold `rst_n=0` with `key=2'b00` (both pressed) → all outputs stay 0 during reset. After release, `key_level=2'b11` at cycle 10 and `key_press=2'b11` at cycle 11.
- Clean press on ch0: drive `key[0]` 1→0 and hold → `key_level[0]` rises 10 cycles later, `key_press[0]` is high for 1 cycle, and `led[0]` rises 1 cycle after `key_level[0]`. On release, `led[0]` falls after the same latency and no pulse occurs.
- Bounce on ch0: hold the pressed level for 7 cycles, release for 1 cycle, then press and hold → exactly one `key_press[0]`, 8 cycles after the final press edge plus 2 for the synchroniser. The 7-cycle burst alone produces no output change.
- Toggle on ch1: three clean presses → `led[1]` sequence 0→1→0→1, each change 1 cycle after its `key_press[1]`. Releases leave `led[1]` unchanged.
- Simultaneous events: press both keys on the same edge → `key_press=2'b11` in the same cycle, `led[0]=1`, and `led[1]` toggles.
- Reset mid-count: drop `rst_n` 5 cycles into a ch1 debounce with `led[1]=1` → `led[1]=0` immediately (asynchronous). After release, the count restarts and needs a full 8 cycles.
